// File: rtl/game_scoreboard_pkg.sv
// Shared constants and types for the game scoreboard: WHO codes, FSM states
// and a saturating counter helper.
package game_scoreboard_pkg;

  localparam logic [1:0] WHO_WIN  = 2'b10;
  localparam logic [1:0] WHO_LOSE = 2'b01;
  localparam logic [1:0] WHO_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DONE    = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_scoreboard_result_fifo.sv
// History FIFO of game outcomes. A pop frees a slot in the same cycle, so a
// push alongside a pop always lands, even when the FIFO is full.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop     = pop && (count_q != '0);
    do_push    = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & ~do_push);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: rd_data is gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow = overflow_q;

endmodule

// File: rtl/game_scoreboard.sv
// Game/match scoreboard: edge-detects GAMEOVER, keeps lifetime and per-match
// counts, runs the IDLE/PLAYING/DONE match FSM and logs outcomes to a FIFO.
module game_scoreboard
  import game_scoreboard_pkg::*;
#(
  parameter int WINS_TO_TAKE = 3,
  parameter int HIST_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       GAMEOVER,
  input  logic [1:0] WHO,
  input  logic       new_match,
  input  logic       rd_en,
  output logic [7:0] win_total,
  output logic [7:0] lose_total,
  output logic [3:0] match_wins,
  output logic [3:0] match_losses,
  output logic       match_over,
  output logic [1:0] match_result,
  output logic [1:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       err_invalid,
  output logic [1:0] dbg_state
);

  localparam logic [3:0] TAKE_CNT = 4'(WINS_TO_TAKE);

  state_e     state_q, state_d;
  logic       go_prev_q, go_prev_d;
  logic [7:0] win_total_q, win_total_d;
  logic [7:0] lose_total_q, lose_total_d;
  logic [3:0] match_wins_q, match_wins_d;
  logic [3:0] match_losses_q, match_losses_d;
  logic       match_over_q, match_over_d;
  logic [1:0] match_result_q, match_result_d;
  logic       err_invalid_q, err_invalid_d;
  logic       game_event, is_win, is_lose, is_bad;

  always_comb begin
    game_event = GAMEOVER & ~go_prev_q;
    is_win     = game_event && (WHO == WHO_WIN);
    is_lose    = game_event && (WHO == WHO_LOSE);
    is_bad     = game_event & ~is_win & ~is_lose;

    go_prev_d      = GAMEOVER;
    win_total_d    = is_win  ? sat_inc8(win_total_q)  : win_total_q;
    lose_total_d   = is_lose ? sat_inc8(lose_total_q) : lose_total_q;
    err_invalid_d  = err_invalid_q | is_bad;

    state_d        = state_q;
    match_wins_d   = match_wins_q;
    match_losses_d = match_losses_q;
    match_result_d = match_result_q;
    match_over_d   = 1'b0;

    // The clear comes first so a same-cycle event opens the fresh match.
    if (new_match) begin
      state_d        = IDLE;
      match_wins_d   = '0;
      match_losses_d = '0;
      match_result_d = WHO_NONE;
    end

    if ((is_win || is_lose) && (state_d != DONE)) begin
      if (is_win) match_wins_d   = match_wins_d + 4'd1;
      else        match_losses_d = match_losses_d + 4'd1;
      if (match_wins_d == TAKE_CNT) begin
        state_d        = DONE;
        match_over_d   = 1'b1;
        match_result_d = WHO_WIN;
      end else if (match_losses_d == TAKE_CNT) begin
        state_d        = DONE;
        match_over_d   = 1'b1;
        match_result_d = WHO_LOSE;
      end else begin
        state_d = PLAYING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      go_prev_q      <= 1'b0;
      win_total_q    <= '0;
      lose_total_q   <= '0;
      match_wins_q   <= '0;
      match_losses_q <= '0;
      match_over_q   <= 1'b0;
      match_result_q <= WHO_NONE;
      err_invalid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      go_prev_q      <= go_prev_d;
      win_total_q    <= win_total_d;
      lose_total_q   <= lose_total_d;
      match_wins_q   <= match_wins_d;
      match_losses_q <= match_losses_d;
      match_over_q   <= match_over_d;
      match_result_q <= match_result_d;
      err_invalid_q  <= err_invalid_d;
    end
  end

  // Read side: rd_data shows the head whenever !empty; rd_en pops it on the
  // next rising edge, and rd_en while empty is ignored.
  result_fifo #(
    .DEPTH (HIST_DEPTH),
    .WIDTH (2)
  ) u_result_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (is_win | is_lose),
    .wr_data  (WHO),
    .pop      (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
  );

  assign win_total    = win_total_q;
  assign lose_total   = lose_total_q;
  assign match_wins   = match_wins_q;
  assign match_losses = match_losses_q;
  assign match_over   = match_over_q;
  assign match_result = match_result_q;
  assign err_invalid  = err_invalid_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_game_scoreboard.sv
// Directed bench for game_scoreboard: stimulus pushes hand-computed expected
// output snapshots into a queue, a negedge monitor pops and compares them.
module tb_game_scoreboard;
  import game_scoreboard_pkg::*;

  localparam int W = 35;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       GAMEOVER = 1'b0;
  logic [1:0] WHO = 2'b00;
  logic       new_match = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] win_total, lose_total;
  logic [3:0] match_wins, match_losses;
  logic       match_over;
  logic [1:0] match_result, rd_data;
  logic       empty, full, overflow, err_invalid;
  logic [1:0] dbg_state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  game_scoreboard #(.WINS_TO_TAKE(3), .HIST_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .GAMEOVER     (GAMEOVER),
    .WHO          (WHO),
    .new_match    (new_match),
    .rd_en        (rd_en),
    .win_total    (win_total),
    .lose_total   (lose_total),
    .match_wins   (match_wins),
    .match_losses (match_losses),
    .match_over   (match_over),
    .match_result (match_result),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .err_invalid  (err_invalid),
    .dbg_state    (dbg_state)
  );

  // Snapshot layout: wt lt mw ml mo mr rd em fu ov er st
  function automatic logic [W-1:0] pack(
    input logic [7:0] wt, input logic [7:0] lt,
    input logic [3:0] mw, input logic [3:0] ml,
    input logic mo, input logic [1:0] mr, input logic [1:0] rd,
    input logic em, input logic fu, input logic ov, input logic er,
    input logic [1:0] st);
    return {wt, lt, mw, ml, mo, mr, rd, em, fu, ov, er, st};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic go, input logic [1:0] who,
                       input logic nm, input logic rd);
    reset     = rst;
    GAMEOVER  = go;
    WHO       = who;
    new_match = nm;
    rd_en     = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic expect_st(input string n, input logic [W-1:0] v);
    exp_q.push_back(v);
    name_q.push_back(n);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] act;
    string        n;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = pack(win_total, lose_total, match_wins, match_losses, match_over,
                 match_result, rd_data, empty, full, overflow, err_invalid,
                 dbg_state);
      n_cmp++;
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: got %h required %h (wt lt mw ml mo mr rd em fu ov er st)",
                 n, act, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
    expect_st("reset", pack(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, IDLE));

    // GAMEOVER held three cycles: one event only
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    expect_st("held_c1", pack(1, 0, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, PLAYING));
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    expect_st("held_c3", pack(1, 0, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, PLAYING));
    idle();

    // Close the match on the third win, then a win while DONE
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    expect_st("win2", pack(2, 0, 2, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, PLAYING));
    idle();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    expect_st("match_close", pack(3, 0, 3, 0, 1, 2'b10, 2'b10, 0, 0, 0, 0, DONE));
    idle();
    expect_st("pulse_end", pack(3, 0, 3, 0, 0, 2'b10, 2'b10, 0, 0, 0, 0, DONE));
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    expect_st("win_in_done", pack(4, 0, 3, 0, 0, 2'b10, 2'b10, 0, 1, 0, 0, DONE));
    idle();

    // FIFO full [W W W W]: loss pushed alongside a pop
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b1);
    expect_st("full_push_pop", pack(4, 1, 3, 0, 0, 2'b10, 2'b10, 0, 1, 0, 0, DONE));
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    expect_st("head_advanced", pack(4, 1, 3, 0, 0, 2'b10, 2'b01, 0, 0, 0, 0, DONE));
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    expect_st("drained", pack(4, 1, 3, 0, 0, 2'b10, 2'b00, 1, 0, 0, 0, DONE));
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    expect_st("pop_empty", pack(4, 1, 3, 0, 0, 2'b10, 2'b00, 1, 0, 0, 0, DONE));

    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    expect_st("new_match", pack(4, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, IDLE));

    // Five losses, no pops
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    expect_st("loss1", pack(4, 2, 0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 0, PLAYING));
    idle();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    idle();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    expect_st("loss_close", pack(4, 4, 0, 3, 1, 2'b01, 2'b01, 0, 0, 0, 0, DONE));
    idle();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    expect_st("loss4_full", pack(4, 5, 0, 3, 0, 2'b01, 2'b01, 0, 1, 0, 0, DONE));
    idle();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    expect_st("overflow", pack(4, 6, 0, 3, 0, 2'b01, 2'b01, 0, 1, 1, 0, DONE));
    idle();

    // Invalid WHO codes
    drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    expect_st("invalid_11", pack(4, 6, 0, 3, 0, 2'b01, 2'b01, 0, 1, 1, 1, DONE));
    idle();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    expect_st("invalid_00", pack(4, 6, 0, 3, 0, 2'b01, 2'b01, 0, 1, 1, 1, DONE));
    idle();

    // new_match with a loss in the same cycle
    drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
    expect_st("nm_plus_loss", pack(4, 7, 0, 1, 0, 2'b00, 2'b01, 0, 1, 1, 1, PLAYING));
    idle();

    // Two wins, then reset mid-match and mid-pulse
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    idle();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    expect_st("mid_match", pack(6, 7, 2, 1, 0, 2'b00, 2'b01, 0, 1, 1, 1, PLAYING));
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    expect_st("reset_mid", pack(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, IDLE));
    drive(1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    expect_st("edge_after_reset", pack(1, 0, 1, 0, 0, 2'b00, 2'b10, 0, 0, 0, 0, PLAYING));
    idle();

    // ---------------- final report ----------------
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/game_scoreboard.md
GAME_SCOREBOARD -- requirements
Module: game_scoreboard

Interface
REQ-001 Parameter WINS_TO_TAKE, default 3: match wins needed by either side to close a match (range 1..15).
REQ-002 Parameter HIST_DEPTH, default 4: result-history FIFO depth (power of two, 2..16).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 GAMEOVER  input  1  game-end strobe from upstream counter; may be high one or more cycles.
REQ-006 WHO  input  2  game outcome, valid while GAMEOVER high: 2'b10 winner, 2'b01 loser.
REQ-007 new_match  input  1  single-cycle request to start a new match.
REQ-008 rd_en  input  1  pop one history entry.
REQ-009 win_total / lose_total  output  8 each  lifetime valid-win / valid-loss counts.
REQ-010 match_wins / match_losses  output  4 each  counts within the current match.
REQ-011 match_over  output  1  one-cycle pulse when a match closes.
REQ-012 match_result  output  2  2'b10 match won, 2'b01 match lost, 2'b00 none; held until next match starts.
REQ-013 rd_data  output  2  head history entry (WHO code); 2'b00 when empty.
REQ-014 empty / full  output  1 each  history FIFO status.
REQ-015 overflow / err_invalid  output  1 each  sticky error flags.

Function
REQ-016 A game event SHALL be the cycle where GAMEOVER=1 and GAMEOVER was 0 the previous cycle; WHO SHALL be sampled in that cycle only.
REQ-017 A held-high GAMEOVER SHALL produce exactly one event; GAMEOVER high in the first cycle after reset SHALL count as an edge.
REQ-018 An event with WHO=2'b00 or 2'b11 SHALL set err_invalid and change no counter, FIFO or FSM state.
REQ-019 Counters and FIFO SHALL reflect a valid event on the first rising edge after the event cycle (1-cycle latency).
REQ-020 win_total and lose_total SHALL saturate at 8'hFF and SHALL count valid events in every FSM state.
REQ-021 Every valid event SHALL be pushed to the FIFO; a push while full and not popping SHALL be dropped and set overflow.
REQ-022 Simultaneous push and pop SHALL both succeed in any occupancy, including full; pop when empty SHALL be ignored.
REQ-023 FSM states SHALL be IDLE, PLAYING and DONE.
REQ-024 IDLE->PLAYING on the first valid event; that event SHALL increment match_wins or match_losses.
REQ-025 PLAYING->DONE in the cycle match_wins or match_losses reaches WINS_TO_TAKE; match_over SHALL pulse and match_result SHALL update on the same edge.
REQ-026 In DONE, events SHALL update totals and FIFO only; match counts SHALL hold.
REQ-027 new_match in any state SHALL clear match_wins, match_losses and match_result and enter IDLE; an event in the same cycle SHALL be applied after the clear, moving to PLAYING with count 1.
REQ-028 new_match SHALL NOT clear totals, FIFO or sticky flags.

Reset
REQ-029 reset SHALL drive FSM to IDLE, all counts to 0, match_over 0, match_result 2'b00, FIFO empty (empty=1, full=0, rd_data 2'b00), overflow 0, err_invalid 0, edge-detect register 0.
REQ-030 reset SHALL take priority over all inputs, including mid-match and mid-GAMEOVER pulse.

Structure
REQ-031 A shared package SHALL hold the WHO code constants (WHO_WIN=2'b10, WHO_LOSE=2'b01, WHO_NONE=2'b00) and the FSM state enum.
REQ-032 The history FIFO SHALL be a sub-module named result_fifo, parameterised by depth and width.

Verification
REQ-033 Reset, then GAMEOVER held 3 cycles with WHO=10 -> win_total=1, match_wins=1, one FIFO entry 2'b10, state PLAYING.
REQ-034 Three win events separated by idle cycles -> match_over pulses once on the third, match_result=2'b10, a fourth win gives win_total=4, match_wins still 3.
REQ-035 Five loss events with no pops -> FIFO full after 4 and overflow=1; lose_total=5, rd_data=2'b01.
REQ-036 FIFO full, push and pop in the same cycle -> full stays 1, overflow stays 0, head advances.
REQ-037 Event with WHO=11 -> err_invalid=1, all counts unchanged; new_match plus a loss event in the same cycle -> match_losses=1, state PLAYING.
REQ-038 Reset asserted mid-match with match_wins=2 -> all outputs at REQ-029 values next cycle.
